// File: rtl/cmul_pkg.sv
// Shared constants and the round-robin grant function for the complex-multiply arbiter.
// Fixed-point format is Q1.14 in a 16-bit word, so CMUL_ONE is 0x4000.
package cmul_pkg;

    localparam int          CMUL_WIDTH  = 16;
    localparam int          CMUL_FRAC   = 14;
    localparam int          CMUL_ONE    = 1 << CMUL_FRAC;
    localparam int unsigned CMUL_MAXREQ = 8;
    localparam int          CMUL_PTR_W  = 3;

    // Grants the first set valid bit at or after ptr+1, wrapping at nreq.
    function automatic logic [CMUL_MAXREQ-1:0] rr_pick(
        input logic [CMUL_MAXREQ-1:0] valid,
        input logic [CMUL_PTR_W-1:0]  ptr,
        input int unsigned            nreq
    );
        logic [CMUL_MAXREQ-1:0] grant;
        logic                   found;
        logic [CMUL_PTR_W-1:0]  idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= CMUL_MAXREQ; k++) begin
            idx = CMUL_PTR_W'((32'(ptr) + k) % nreq);
            if (k <= nreq && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/Multiply.sv
// Combinational complex multiply built from four qmult products.
// The final add and subtract wrap modulo 2^WIDTH.
module Multiply #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14
) (
    input  logic signed [WIDTH-1:0] i_a_re,
    input  logic signed [WIDTH-1:0] i_a_im,
    input  logic signed [WIDTH-1:0] i_b_re,
    input  logic signed [WIDTH-1:0] i_b_im,
    output logic signed [WIDTH-1:0] o_re,
    output logic signed [WIDTH-1:0] o_im
);

    logic signed [WIDTH-1:0] w_rr, w_ii, w_ri, w_ir;

    qmult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_rr (.i_a(i_a_re), .i_b(i_b_re), .o_y(w_rr));
    qmult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_ii (.i_a(i_a_im), .i_b(i_b_im), .o_y(w_ii));
    qmult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_ri (.i_a(i_a_re), .i_b(i_b_im), .o_y(w_ri));
    qmult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_ir (.i_a(i_a_im), .i_b(i_b_re), .o_y(w_ir));

    assign o_re = w_rr - w_ii;
    assign o_im = w_ri + w_ir;

endmodule

// File: rtl/qmult.sv
// Signed fixed-point multiply: full-precision product, arithmetic shift right by FRAC,
// truncated to WIDTH bits (floor toward minus infinity, upper bits discarded).
module qmult #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_y
);

    function automatic logic signed [WIDTH-1:0] mul_trunc(
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] y
    );
        return WIDTH'(((2*WIDTH)'(x) * (2*WIDTH)'(y)) >>> FRAC);
    endfunction

    assign o_y = mul_trunc(i_a, i_b);

endmodule

// File: rtl/cmul_share_arbiter.sv
// Round-robin shares one complex multiplier among NREQ requesters through a
// two-stage pipeline (operand register, result register); results carry the requester id.
module cmul_share_arbiter
    import cmul_pkg::*;
#(
    parameter int WIDTH = CMUL_WIDTH,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a_re,
    input  logic [NREQ*WIDTH-1:0]   req_a_im,
    input  logic [NREQ*WIDTH-1:0]   req_b_re,
    input  logic [NREQ*WIDTH-1:0]   req_b_im,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [IDW-1:0]          res_id,
    output logic signed [WIDTH-1:0] res_re,
    output logic signed [WIDTH-1:0] res_im
);

    logic [CMUL_MAXREQ-1:0]  w_pick;
    logic [NREQ-1:0]         w_grant;
    logic                    w_any, w_accept, w_s1_free, w_s2_free;
    logic [IDW-1:0]          w_gidx;
    logic signed [WIDTH-1:0] w_sel_a_re, w_sel_a_im, w_sel_b_re, w_sel_b_im;
    logic signed [WIDTH-1:0] w_mul_re, w_mul_im;

    logic [IDW-1:0]          r_rr_ptr;
    logic                    r_vld_p1, r_vld_p2;
    logic [IDW-1:0]          r_id_p1, r_id_p2;
    logic signed [WIDTH-1:0] r_a_re_p1, r_a_im_p1, r_b_re_p1, r_b_im_p1;
    logic signed [WIDTH-1:0] r_re_p2, r_im_p2;

    assign w_s2_free = !r_vld_p2 || res_ready;
    assign w_s1_free = !r_vld_p1 || w_s2_free;

    assign w_pick    = rr_pick(CMUL_MAXREQ'(req_valid), CMUL_PTR_W'(r_rr_ptr), NREQ);
    assign w_grant   = w_pick[NREQ-1:0];
    assign w_any     = |w_pick;
    assign w_accept  = w_any && w_s1_free;
    assign req_ready = w_grant & {NREQ{w_s1_free}};

    always_comb begin
        w_gidx     = '0;
        w_sel_a_re = '0;
        w_sel_a_im = '0;
        w_sel_b_re = '0;
        w_sel_b_im = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gidx     = IDW'(i);
                w_sel_a_re = req_a_re[i*WIDTH +: WIDTH];
                w_sel_a_im = req_a_im[i*WIDTH +: WIDTH];
                w_sel_b_re = req_b_re[i*WIDTH +: WIDTH];
                w_sel_b_im = req_b_im[i*WIDTH +: WIDTH];
            end
        end
    end

    // Stage 1: granted operands and id
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a_re_p1 <= w_sel_a_re;
            r_a_im_p1 <= w_sel_a_im;
            r_b_re_p1 <= w_sel_b_re;
            r_b_im_p1 <= w_sel_b_im;
            r_id_p1   <= w_gidx;
        end
    end

    Multiply #(.WIDTH(WIDTH), .FRAC(CMUL_FRAC)) u_mult (
        .i_a_re (r_a_re_p1),
        .i_a_im (r_a_im_p1),
        .i_b_re (r_b_re_p1),
        .i_b_im (r_b_im_p1),
        .o_re   (w_mul_re),
        .o_im   (w_mul_im)
    );

    // Stage 2: multiply result; S2 holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= IDW'(NREQ - 1);
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_id_p2  <= '0;
            r_re_p2  <= '0;
            r_im_p2  <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= w_gidx;
            end
            if (w_s1_free) begin
                r_vld_p1 <= w_accept;
            end
            if (w_s2_free) begin
                r_vld_p2 <= r_vld_p1;
                if (r_vld_p1) begin
                    r_id_p2 <= r_id_p1;
                    r_re_p2 <= w_mul_re;
                    r_im_p2 <= w_mul_im;
                end
            end
        end
    end

    assign res_valid = r_vld_p2;
    assign res_id    = r_id_p2;
    assign res_re    = r_re_p2;
    assign res_im    = r_im_p2;

endmodule

// File: tb/tb_cmul_share_arbiter.sv
// Directed bench for cmul_share_arbiter: arbitration order, latency, backpressure,
// wrap-around arithmetic and mid-flight reset, with hand-computed expected values.
module tb_cmul_share_arbiter;

    localparam int W = 16;
    localparam int N = 4;
    localparam logic [15:0] ONE = 16'h4000;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a_re, req_a_im, req_b_re, req_b_im;
    logic           res_valid;
    logic           res_ready;
    logic [1:0]     res_id;
    logic [W-1:0]   res_re, res_im;

    logic [15:0] a_re[N], a_im[N], b_re[N], b_im[N];

    // Expected result per requester for the default operand table
    logic [15:0] exp_re[N];
    logic [15:0] exp_im[N];

    int n_checks = 0;
    int n_errors = 0;

    int          acc_q[$];
    int          got_id[$];
    logic [15:0] got_re[$];
    logic [15:0] got_im[$];

    cmul_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a_re  (req_a_re),
        .req_a_im  (req_a_im),
        .req_b_re  (req_b_re),
        .req_b_im  (req_b_im),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_re    (res_re),
        .res_im    (res_im)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        req_a_re = '0;
        req_a_im = '0;
        req_b_re = '0;
        req_b_im = '0;
        for (int i = 0; i < N; i++) begin
            req_a_re[i*W +: W] = a_re[i];
            req_a_im[i*W +: W] = a_im[i];
            req_b_re[i*W +: W] = b_re[i];
            req_b_im[i*W +: W] = b_im[i];
        end
    end

    // Records transfers that complete on the coming rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) acc_q.push_back(i);
            end
            if (res_valid && res_ready) begin
                got_id.push_back(int'(res_id));
                got_re.push_back(res_re);
                got_im.push_back(res_im);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_q();
        acc_q.delete();
        got_id.delete();
        got_re.delete();
        got_im.delete();
    endtask

    task automatic chk_got(input string tag, input int k, input int id,
                           input logic [15:0] re, input logic [15:0] im);
        chk({tag, "_id"}, 32'(got_id[k]), 32'(id));
        chk({tag, "_re"}, 32'(got_re[k]), 32'(re));
        chk({tag, "_im"}, 32'(got_im[k]), 32'(im));
    endtask

    // Requesters 0..2 send a=(ONE,0) so the result equals b; requester 3 sends a=(0,ONE)
    task automatic load_table();
        b_re[0] = 16'h0100; b_im[0] = 16'h0011;
        b_re[1] = 16'h0200; b_im[1] = 16'hFFDE;
        b_re[2] = 16'hFD00; b_im[2] = 16'h0033;
        b_re[3] = 16'h1234; b_im[3] = 16'h0044;
        for (int i = 0; i < 3; i++) begin
            a_re[i] = ONE; a_im[i] = 16'h0000;
            exp_re[i] = b_re[i]; exp_im[i] = b_im[i];
        end
        a_re[3] = 16'h0000; a_im[3] = ONE;
        exp_re[3] = 16'hFFBC; exp_im[3] = 16'h1234;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_q();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        load_table();

        // Test 1: reset state, then (0,ONE)*(0,ONE) = (-ONE,0)
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_id",    32'(res_id),    32'd0);
        chk("rst_re",    32'(res_re),    32'd0);
        chk("rst_im",    32'(res_im),    32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        a_re[0] = 16'h0000; a_im[0] = ONE; b_re[0] = 16'h0000; b_im[0] = ONE;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_lat1_valid", 32'(res_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_id",    32'(res_id),    32'd0);
        chk("t1_re",    32'(res_re),    32'h0000C000);
        chk("t1_im",    32'(res_im),    32'h00000000);
        tick();
        load_table();

        // Test 2: all requesters continuously valid, full throughput
        do_reset();
        req_valid = 4'b1111;
        repeat (8) tick();
        req_valid = '0;
        repeat (3) tick();
        chk("t2_acc_n", 32'(acc_q.size()), 32'd8);
        chk("t2_got_n", 32'(got_id.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("t2_acc_id", 32'(acc_q[k]), 32'(k % 4));
            chk_got("t2_res", k, k % 4, exp_re[k % 4], exp_im[k % 4]);
        end

        // Test 3: backpressure with everyone valid; pointer is now 3
        clr_q();
        res_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t3_ready",     32'(req_ready),    32'd0);
        chk("t3_acc_n",     32'(acc_q.size()), 32'd2);
        chk("t3_hold_vld",  32'(res_valid),    32'd1);
        chk("t3_hold_id",   32'(res_id),       32'd0);
        chk("t3_hold_re",   32'(res_re),       32'(exp_re[0]));
        chk("t3_hold_im",   32'(res_im),       32'(exp_im[0]));
        tick();
        res_ready = 1'b1;
        req_valid = '0;
        repeat (4) tick();
        chk("t3_got_n", 32'(got_id.size()), 32'd2);
        chk_got("t3_res0", 0, 0, exp_re[0], exp_im[0]);
        chk_got("t3_res1", 1, 1, exp_re[1], exp_im[1]);
        chk("t3_acc_n_final", 32'(acc_q.size()), 32'd2);

        // Test 4: lone requester 2, then 1 and 3 contend after pointer moved to 2
        clr_q();
        b_re[2] = 16'h0123; b_im[2] = 16'hFFBB;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t4_ready2", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        repeat (3) tick();
        chk("t4_got_n", 32'(got_id.size()), 32'd1);
        chk_got("t4_res", 0, 2, 16'h0123, 16'hFFBB);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("t4_ready3", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("t4_ready1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        repeat (3) tick();
        chk("t4_got_n2", 32'(got_id.size()), 32'd3);
        chk_got("t4_res3", 1, 3, exp_re[3], exp_im[3]);
        chk_got("t4_res1", 2, 1, exp_re[1], exp_im[1]);
        load_table();

        // Test 5: overflow; products truncate and sums wrap
        clr_q();
        a_re[0] = 16'h7FFF; a_im[0] = 16'h7FFF; b_re[0] = 16'h7FFF; b_im[0] = 16'h7FFF;
        req_valid = 4'b0001;
        tick();
        b_im[0] = 16'h8001;
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t5_valid", 32'(res_valid), 32'd1);
        chk("t5_re",    32'(res_re),    32'h0000);
        chk("t5_im",    32'(res_im),    32'hFFF8);
        chk("t5_nox",   32'($isunknown({res_re, res_im})), 32'd0);
        repeat (3) tick();
        chk("t5_got_n", 32'(got_id.size()), 32'd2);
        chk_got("t5_res1", 1, 0, 16'hFFF9, 16'hFFFF);
        load_table();

        // Test 6: reset with two results in flight
        clr_q();
        res_ready = 1'b0;
        req_valid = 4'b0011;
        repeat (2) tick();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        repeat (3) tick();
        chk("t6_no_stale", 32'(got_id.size()), 32'd0);
        chk("t6_valid_lo", 32'(res_valid), 32'd0);
        req_valid = 4'b0101;
        @(negedge clk);
        chk("t6_ready0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (3) tick();
        chk("t6_got_n", 32'(got_id.size()), 32'd2);
        chk_got("t6_res0", 0, 0, exp_re[0], exp_im[0]);
        chk_got("t6_res2", 1, 2, exp_re[2], exp_im[2]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
